// File: rtl/e203_icb_slv_ram.sv
// ICB responder with a word-addressed RAM, byte-mask writes and a fixed response latency.
// Optional exclusive-access reservation monitor: define E203_ICB_SLV_EXCL_EN.
module e203_icb_slv_ram #(
  parameter int AW    = 16,
  parameter int DEPTH = 64,
  parameter int OUTS  = 2,
  parameter int LAT   = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          icb_cmd_valid,
  output logic          icb_cmd_ready,
  input  logic [AW-1:0] icb_cmd_addr,
  input  logic          icb_cmd_read,
  input  logic [31:0]   icb_cmd_wdata,
  input  logic [3:0]    icb_cmd_wmask,
  input  logic          icb_cmd_excl,
  output logic          icb_rsp_valid,
  input  logic          icb_rsp_ready,
  output logic          icb_rsp_err,
  output logic          icb_rsp_excl_ok,
  output logic [31:0]   icb_rsp_rdata,
  output logic          busy
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = (OUTS > 1) ? $clog2(OUTS) : 1;
  localparam int CW = $clog2(OUTS + 1);
  localparam logic [3:0]    LAT_W  = 4'(LAT);
  localparam logic [CW-1:0] OUTS_W = CW'(OUTS);

  logic [31:0]   mem_q [DEPTH];

  logic [31:0]   ent_rdata_q [OUTS];
  logic          ent_err_q   [OUTS];
  logic          ent_excl_q  [OUTS];
  logic [3:0]    ent_wait_q  [OUTS];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q, count_d;

  logic [IW-1:0] idx;
  logic          oor, push, pop, wr_en;
  logic          new_err, new_excl;
  logic [31:0]   new_rdata;

  assign idx = icb_cmd_addr[IW+1:2];
  assign oor = |icb_cmd_addr[AW-1:IW+2];

  // cmd_ready depends only on the registered count, never on rsp_ready
  assign icb_cmd_ready   = (count_q != OUTS_W);
  assign push            = icb_cmd_valid & icb_cmd_ready;
  assign icb_rsp_valid   = (count_q != '0) && (ent_wait_q[rptr_q] == 4'd0);
  assign pop             = icb_rsp_valid & icb_rsp_ready;
  assign icb_rsp_err     = ent_err_q[rptr_q];
  assign icb_rsp_excl_ok = ent_excl_q[rptr_q];
  assign icb_rsp_rdata   = ent_rdata_q[rptr_q];
  assign busy            = (count_q != '0);
  assign count_d         = count_q + CW'(push) - CW'(pop);

`ifdef E203_ICB_SLV_EXCL_EN
  logic          resv_vld_q, resv_vld_d;
  logic [IW-1:0] resv_idx_q, resv_idx_d;
  logic          unused_ok;
  assign unused_ok = ^icb_cmd_addr[1:0];
`else
  logic          unused_ok;
  assign unused_ok = ^{icb_cmd_excl, icb_cmd_addr[1:0]};
`endif

  always_comb begin
    wr_en     = 1'b0;
    new_err   = oor;
    new_excl  = 1'b0;
    new_rdata = '0;
    if (!oor) begin
      if (icb_cmd_read) new_rdata = mem_q[idx];
      else              wr_en     = 1'b1;
    end
`ifdef E203_ICB_SLV_EXCL_EN
    resv_vld_d = resv_vld_q;
    resv_idx_d = resv_idx_q;
    if (push && !oor) begin
      if (icb_cmd_read && icb_cmd_excl) begin
        resv_vld_d = 1'b1;
        resv_idx_d = idx;
        new_excl   = 1'b1;
      end else if (!icb_cmd_read && icb_cmd_excl) begin
        if (resv_vld_q && (resv_idx_q == idx)) begin
          new_excl   = 1'b1;
          resv_vld_d = 1'b0;
        end else begin
          wr_en = 1'b0;
        end
      end else if (!icb_cmd_read && resv_vld_q && (resv_idx_q == idx)) begin
        resv_vld_d = 1'b0;
      end
    end
`endif
  end

`ifdef E203_ICB_SLV_EXCL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resv_vld_q <= 1'b0;
      resv_idx_q <= '0;
    end else begin
      resv_vld_q <= resv_vld_d;
      resv_idx_q <= resv_idx_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (push && wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (icb_cmd_wmask[b]) mem_q[idx][8*b +: 8] <= icb_cmd_wdata[8*b +: 8];
      end
    end
  end

  // every entry ages in parallel; a fresh push overrides the slot's counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      for (int i = 0; i < OUTS; i++) begin
        ent_rdata_q[i] <= '0;
        ent_err_q[i]   <= 1'b0;
        ent_excl_q[i]  <= 1'b0;
        ent_wait_q[i]  <= 4'd0;
      end
    end else begin
      for (int i = 0; i < OUTS; i++) begin
        if (ent_wait_q[i] != 4'd0) ent_wait_q[i] <= ent_wait_q[i] - 4'd1;
      end
      if (push) begin
        ent_rdata_q[wptr_q] <= new_rdata;
        ent_err_q[wptr_q]   <= new_err;
        ent_excl_q[wptr_q]  <= new_excl;
        ent_wait_q[wptr_q]  <= LAT_W;
        wptr_q <= (wptr_q == PW'(OUTS - 1)) ? '0 : wptr_q + PW'(1);
      end
      if (pop) rptr_q <= (rptr_q == PW'(OUTS - 1)) ? '0 : rptr_q + PW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_e203_icb_slv_ram.sv
// Scoreboard bench for e203_icb_slv_ram: LAT=0 instance for data paths, LAT=3 instance for timing/reset.
module tb_e203_icb_slv_ram;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_read, cmd_excl;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wmask;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_excl_ok, busy;
  logic [31:0] rsp_rdata;

  logic        c2_rst, c2_cmd_valid, c2_cmd_ready;
  logic        c2_rsp_valid, c2_rsp_err, c2_rsp_excl_ok, c2_busy;
  logic [31:0] c2_rsp_rdata;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        excl;
  } exp_t;
  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  e203_icb_slv_ram #(.AW(16), .DEPTH(64), .OUTS(2), .LAT(0)) u_dut (
    .clk(clk), .rst(rst),
    .icb_cmd_valid(cmd_valid), .icb_cmd_ready(cmd_ready), .icb_cmd_addr(cmd_addr),
    .icb_cmd_read(cmd_read), .icb_cmd_wdata(cmd_wdata), .icb_cmd_wmask(cmd_wmask),
    .icb_cmd_excl(cmd_excl), .icb_rsp_valid(rsp_valid), .icb_rsp_ready(rsp_ready),
    .icb_rsp_err(rsp_err), .icb_rsp_excl_ok(rsp_excl_ok), .icb_rsp_rdata(rsp_rdata),
    .busy(busy)
  );

  e203_icb_slv_ram #(.AW(16), .DEPTH(64), .OUTS(2), .LAT(3)) u_dut_lat (
    .clk(clk), .rst(c2_rst),
    .icb_cmd_valid(c2_cmd_valid), .icb_cmd_ready(c2_cmd_ready), .icb_cmd_addr(16'h0008),
    .icb_cmd_read(1'b1), .icb_cmd_wdata(32'h0), .icb_cmd_wmask(4'h0),
    .icb_cmd_excl(1'b0), .icb_rsp_valid(c2_rsp_valid), .icb_rsp_ready(1'b1),
    .icb_rsp_err(c2_rsp_err), .icb_rsp_excl_ok(c2_rsp_excl_ok), .icb_rsp_rdata(c2_rsp_rdata),
    .busy(c2_busy)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic send(input logic rd, input logic [15:0] addr, input logic [31:0] wd,
                      input logic [3:0] wm, input logic ex,
                      input logic [31:0] e_rdata, input logic e_err, input logic e_excl);
    int n = 0;
    exp_t e;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_read  = rd;
    cmd_addr  = addr;
    cmd_wdata = wd;
    cmd_wmask = wm;
    cmd_excl  = ex;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      chk("accept_timeout", {31'b0, cmd_ready}, 32'd1);
    end else begin
      e.rdata = e_rdata;
      e.err   = e_err;
      e.excl  = e_excl;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((sb_q.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'b0, busy}, 32'd0);
    chk({tag, "_sb"}, sb_q.size(), 32'd0);
  endtask

  // a response is consumed at the posedge following a negedge where valid and ready are high
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        chk("rsp_unexpected", {31'b0, rsp_valid}, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
        chk("rsp_excl_ok", {31'b0, rsp_excl_ok}, {31'b0, e.excl});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    c2_rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_read = 1'b0;
    cmd_addr = '0;
    cmd_wdata = '0;
    cmd_wmask = '0;
    cmd_excl = 1'b0;
    rsp_ready = 1'b1;
    c2_cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("rst_excl_ok", {31'b0, rsp_excl_ok}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    rst = 1'b0;
    c2_rst = 1'b0;

    // write/read with single-cycle response latency
    send(1'b0, 16'h0008, 32'hA5A5_1234, 4'hF, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("lat0_wr_valid", {31'b0, rsp_valid}, 32'd1);
    send(1'b1, 16'h0008, 32'h0, 4'h0, 1'b0, 32'hA5A5_1234, 1'b0, 1'b0);
    @(negedge clk);
    chk("lat0_rd_valid", {31'b0, rsp_valid}, 32'd1);

    // byte mask
    send(1'b0, 16'h0010, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0, 1'b0, 1'b0);
    send(1'b0, 16'h0012, 32'h1122_3344, 4'h5, 1'b0, 32'h0, 1'b0, 1'b0);
    send(1'b1, 16'h0010, 32'h0, 4'h0, 1'b0, 32'hFF22_FF44, 1'b0, 1'b0);

    // out of range: 0x0100 aliases word 0 if the upper bits were ignored
    send(1'b0, 16'h0000, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0, 1'b0, 1'b0);
    send(1'b1, 16'h0100, 32'h0, 4'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    send(1'b0, 16'h0100, 32'h1234_5678, 4'hF, 1'b0, 32'h0, 1'b1, 1'b0);
    send(1'b1, 16'h0000, 32'h0, 4'h0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    send(1'b1, 16'h8004, 32'h0, 4'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    wait_idle("idle_basic");

    // backpressure: two outstanding, third blocked until the stall clears
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    send(1'b1, 16'h0008, 32'h0, 4'h0, 1'b0, 32'hA5A5_1234, 1'b0, 1'b0);
    send(1'b1, 16'h0010, 32'h0, 4'h0, 1'b0, 32'hFF22_FF44, 1'b0, 1'b0);
    @(negedge clk);
    chk("bp_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    chk("bp_busy", {31'b0, busy}, 32'd1);
    fork
      send(1'b1, 16'h0000, 32'h0, 4'h0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0);
      begin
        repeat (3) @(negedge clk);
        chk("bp_stall_valid", {31'b0, rsp_valid}, 32'd1);
        chk("bp_stall_rdata", rsp_rdata, 32'hA5A5_1234);
        chk("bp_still_full", {31'b0, cmd_ready}, 32'd0);
        @(posedge clk);
        #1 rsp_ready = 1'b1;
      end
    join
    wait_idle("idle_bp");
    chk("bp_ready_back", {31'b0, cmd_ready}, 32'd1);

    // exclusive accesses
    send(1'b0, 16'h0020, 32'h0, 4'hF, 1'b0, 32'h0, 1'b0, 1'b0);
`ifdef E203_ICB_SLV_EXCL_EN
    send(1'b1, 16'h0020, 32'h0, 4'h0, 1'b1, 32'h0, 1'b0, 1'b1);
    send(1'b0, 16'h0020, 32'h5, 4'hF, 1'b1, 32'h0, 1'b0, 1'b1);
    send(1'b0, 16'h0020, 32'h6, 4'hF, 1'b1, 32'h0, 1'b0, 1'b0);
    send(1'b1, 16'h0020, 32'h0, 4'h0, 1'b0, 32'h5, 1'b0, 1'b0);
`else
    send(1'b1, 16'h0020, 32'h0, 4'h0, 1'b1, 32'h0, 1'b0, 1'b0);
    send(1'b0, 16'h0020, 32'h5, 4'hF, 1'b1, 32'h0, 1'b0, 1'b0);
    send(1'b0, 16'h0020, 32'h6, 4'hF, 1'b1, 32'h0, 1'b0, 1'b0);
    send(1'b1, 16'h0020, 32'h0, 4'h0, 1'b0, 32'h6, 1'b0, 1'b0);
`endif
    wait_idle("idle_excl");

    // LAT=3: accepted in cycle N, first visible in cycle N+4
    @(negedge clk);
    c2_cmd_valid = 1'b1;
    chk("lat3_cmd_ready", {31'b0, c2_cmd_ready}, 32'd1);
    @(posedge clk);
    #1 c2_cmd_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("lat3_valid_c%0d", k), {31'b0, c2_rsp_valid}, {31'b0, (k == 4)});
      if (k == 1) chk("lat3_busy", {31'b0, c2_busy}, 32'd1);
    end

    // reset two cycles after accept flushes the pending response
    @(negedge clk);
    c2_cmd_valid = 1'b1;
    @(posedge clk);
    #1 c2_cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    c2_rst = 1'b1;
    #1;
    chk("lat3_rst_ready", {31'b0, c2_cmd_ready}, 32'd1);
    chk("lat3_rst_valid", {31'b0, c2_rsp_valid}, 32'd0);
    chk("lat3_rst_busy", {31'b0, c2_busy}, 32'd0);
    for (int k = 3; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("lat3_rst_valid_c%0d", k), {31'b0, c2_rsp_valid}, 32'd0);
    end
    c2_rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("lat3_post_rst_valid", {31'b0, c2_rsp_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
